// File: rtl/pad_cfg_sequencer_pkg.sv
// Shared constants for the pad configuration sequencer: pad count, register
// offsets, CTRL/STATUS bit positions, sequencer states and reset direction.
package pads_cfg_pkg;

    localparam int NPAD = 44;

    // Per-pad oe_n after reset (1 = input).
    localparam logic [43:0] DEF_RST_OEN = 44'hC70003FFFBD;

    // Register offsets (wbs_adr_i[7:0]).
    localparam logic [7:0] OFS_SHD_OEN_LO  = 8'h00;
    localparam logic [7:0] OFS_SHD_OEN_HI  = 8'h04;
    localparam logic [7:0] OFS_SHD_REN_LO  = 8'h08;
    localparam logic [7:0] OFS_SHD_REN_HI  = 8'h0C;
    localparam logic [7:0] OFS_CTRL        = 8'h10;
    localparam logic [7:0] OFS_STATUS      = 8'h14;
    localparam logic [7:0] OFS_LIVE_OEN_LO = 8'h18;
    localparam logic [7:0] OFS_LIVE_OEN_HI = 8'h1C;

    // CTRL and STATUS bit positions.
    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_OVR_BIT     = 1;
    localparam int STAT_TURN_LSB    = 8;

    // Commit sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DRIVE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pad_cfg_sequencer_wb_regs.sv
// Wishbone slave for the pad sequencer: address decode, single-cycle ack,
// OEN/REN shadow registers with byte selects, read mux, and the commit /
// overrun-clear pulses that feed the sequencer.
module pad_cfg_wb_regs #(
    parameter int              NPAD      = pads_cfg_pkg::NPAD,
    parameter logic [19:0]     BASE_ADDR = 20'h30007,
    parameter int              TURN_CYC  = 4,
    parameter logic [NPAD-1:0] RST_OEN   = pads_cfg_pkg::DEF_RST_OEN
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic            busy,
    input  logic            ovr,
    input  logic [NPAD-1:0] live_oen,
    output logic [NPAD-1:0] shd_oen,
    output logic [NPAD-1:0] shd_ren,
    output logic            commit,
    output logic            clr_ovr
);
    import pads_cfg_pkg::*;

    localparam int HI_W = NPAD - 32;

    logic        access;
    logic        wr;
    logic [7:0]  ofs;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic        unused_adr;

    // Bits 11:8 of the address are not part of the decode.
    assign unused_adr = ^wbs_adr_i[11:8];

    // The ~ack term makes a held strobe complete on alternate cycles.
    assign access  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR) & ~wbs_ack_o;
    assign ofs     = wbs_adr_i[7:0];
    assign wr      = access & wbs_we_i;
    assign commit  = wr & (ofs == OFS_CTRL) & wbs_dat_i[CTRL_COMMIT_BIT];
    assign clr_ovr = wr & (ofs == OFS_CTRL) & wbs_dat_i[CTRL_CLR_OVR_BIT];

    // Expand byte selects into a per-bit write mask.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    // Read data mux; unmapped and write-only offsets read zero.
    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_SHD_OEN_LO:  rdata = shd_oen[31:0];
            OFS_SHD_OEN_HI:  rdata[HI_W-1:0] = shd_oen[NPAD-1:32];
            OFS_SHD_REN_LO:  rdata = shd_ren[31:0];
            OFS_SHD_REN_HI:  rdata[HI_W-1:0] = shd_ren[NPAD-1:32];
            OFS_STATUS: begin
                rdata[STAT_BUSY_BIT]         = busy;
                rdata[STAT_OVR_BIT]          = ovr;
                rdata[STAT_TURN_LSB +: 8]    = 8'(TURN_CYC);
            end
            OFS_LIVE_OEN_LO: rdata = live_oen[31:0];
            OFS_LIVE_OEN_HI: rdata[HI_W-1:0] = live_oen[NPAD-1:32];
            default:         rdata = '0;
        endcase
    end

    // Bus handshake: one-cycle ack, read data valid only alongside ack.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access & ~wbs_we_i) ? rdata : '0;
        end
    end

    // Shadow register writes, byte-lane masked; independent of the sequencer.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shd_oen <= RST_OEN;
            shd_ren <= '1;
        end else if (wr) begin
            case (ofs)
                OFS_SHD_OEN_LO: shd_oen[31:0] <= (shd_oen[31:0] & ~wmask) | (wbs_dat_i & wmask);
                OFS_SHD_OEN_HI: shd_oen[NPAD-1:32] <= (shd_oen[NPAD-1:32] & ~wmask[HI_W-1:0])
                                                      | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                OFS_SHD_REN_LO: shd_ren[31:0] <= (shd_ren[31:0] & ~wmask) | (wbs_dat_i & wmask);
                OFS_SHD_REN_HI: shd_ren[NPAD-1:32] <= (shd_ren[NPAD-1:32] & ~wmask[HI_W-1:0])
                                                      | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Pad direction/pull sequencer. A commit applies the shadow OEN/REN values
// break-before-make: release drivers first, hold off for TURN_CYC cycles if
// any pad is about to start driving, then enable new drivers and pulls.
module pad_cfg_sequencer #(
    parameter int              NPAD      = pads_cfg_pkg::NPAD,
    parameter logic [19:0]     BASE_ADDR = 20'h30007,
    parameter int              TURN_CYC  = 4,
    parameter logic [NPAD-1:0] RST_OEN   = pads_cfg_pkg::DEF_RST_OEN
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [NPAD-1:0] oe_n,
    output logic [NPAD-1:0] re_n,
    output logic            busy
);
    import pads_cfg_pkg::*;

    seq_state_t      state;
    logic [7:0]      cnt;
    logic [NPAD-1:0] oe_q;
    logic [NPAD-1:0] re_q;
    logic [NPAD-1:0] tgt_oen;
    logic [NPAD-1:0] tgt_ren;
    logic [NPAD-1:0] shd_oen;
    logic [NPAD-1:0] shd_ren;
    logic            ovr;
    logic            commit;
    logic            clr_ovr;
    logic            new_drv;

    pad_cfg_wb_regs #(
        .NPAD      (NPAD),
        .BASE_ADDR (BASE_ADDR),
        .TURN_CYC  (TURN_CYC),
        .RST_OEN   (RST_OEN)
    ) u_regs (
        .clk       (clk),
        .resetb    (resetb),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .busy      (busy),
        .ovr       (ovr),
        .live_oen  (oe_q),
        .shd_oen   (shd_oen),
        .shd_ren   (shd_ren),
        .commit    (commit),
        .clr_ovr   (clr_ovr)
    );

    assign busy    = (state != ST_IDLE);
    // Pads that are inputs now but will drive once the targets land.
    assign new_drv = |(oe_q & ~tgt_oen);

    // Reset overrides the pads combinationally so they float with pulls on.
    assign oe_n = resetb ? oe_q : '1;
    assign re_n = resetb ? re_q : '0;

    // Commit sequencer: capture targets, release, turnaround wait, drive.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            oe_q    <= RST_OEN;
            re_q    <= '1;
            tgt_oen <= RST_OEN;
            tgt_ren <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        tgt_oen <= shd_oen;
                        tgt_ren <= shd_ren;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    oe_q <= oe_q | tgt_oen;
                    if (new_drv) begin
                        cnt   <= 8'(TURN_CYC - 1);
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_DRIVE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 8'd0) begin
                        state <= ST_DRIVE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    oe_q  <= tgt_oen;
                    re_q  <= tgt_ren;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overrun flag for commits issued while a sequence is running.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ovr <= 1'b0;
        end else if (clr_ovr) begin
            ovr <= 1'b0;
        end else if (commit && busy) begin
            ovr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Testbench for pad_cfg_sequencer: Wishbone transactions push their expected
// read data into a scoreboard queue that is popped on every ack; pad outputs
// are checked cycle by cycle around commits, plus a break-before-make monitor.
module tb_pad_cfg_sequencer;
    import pads_cfg_pkg::*;

    localparam logic [43:0] RSTV = 44'hC70003FFFBD;
    localparam logic [43:0] ALL1 = 44'hFFFFFFFFFFF;
    localparam logic [31:0] BASE = 32'h3000_7000;

    logic        clk;
    logic        resetb;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [43:0] oe_n;
    logic [43:0] re_n;
    logic        busy;

    pad_cfg_sequencer #(
        .NPAD      (44),
        .BASE_ADDR (20'h30007),
        .TURN_CYC  (4),
        .RST_OEN   (RSTV)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .oe_n      (oe_n),
        .re_n      (re_n),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    logic [43:0] prev_oe = 44'hFFFFFFFFFFF;
    logic        bbm_viol;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; expected ack data goes to the scoreboard first.
    task automatic wb(input logic we, input logic [7:0] ofs, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        exp_q.push_back(we ? 32'h0 : exp_rd);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = BASE | {24'h0, ofs};
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_dat_i = 32'h0;
        wbs_sel_i = 4'h0;
        chk("ack", 64'(wbs_ack_o), 64'd1);
        $display("wb %s ofs=%02h dat=%08h sel=%b exp_rd=%08h", we ? "wr" : "rd", ofs, dat, sel, exp_rd);
    endtask

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetb = 1'b0;
        #2;
        @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("rst_pulse_oe_n", 64'(oe_n), 64'(RSTV));
    endtask

    // Scoreboard: every ack consumes one expected entry.
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                chk("sb_spurious_ack", 64'(exp_q.size()), 64'd1);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_rdata", 64'(wbs_dat_o), 64'(sb_e));
            end
        end
    end

    // No pad may start driving in the same cycle another pad stops.
    always @(negedge clk) begin
        bbm_viol = (|(prev_oe & ~oe_n)) && (|(~prev_oe & oe_n));
        chk("bbm", 64'(bbm_viol), 64'd0);
        prev_oe = oe_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [43:0] mid_oe;
        logic [43:0] fin_oe;
        mid_oe = RSTV | 44'h2;
        fin_oe = (RSTV | 44'h2) & ~44'h100;

        resetb    = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_dat_i = 32'h0;
        wbs_adr_i = 32'h0;
        #1 resetb = 1'b0;

        // Reset state and release.
        #11;
        chk("rst_oe_n", 64'(oe_n), 64'(ALL1));
        chk("rst_re_n", 64'(re_n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("post_oe_n", 64'(oe_n), 64'(RSTV));
        chk("post_re_n", 64'(re_n), 64'(ALL1));
        wb(1'b0, OFS_LIVE_OEN_LO, 32'h0, 4'hF, 32'h003FFFBD);
        wb(1'b0, OFS_LIVE_OEN_HI, 32'h0, 4'hF, 32'h00000C70);
        wb(1'b0, OFS_SHD_OEN_LO,  32'h0, 4'hF, 32'h003FFFBD);
        wb(1'b0, OFS_STATUS,      32'h0, 4'hF, 32'h00000400);
        wb(1'b0, OFS_CTRL,        32'h0, 4'hF, 32'h00000000);
        wb(1'b0, 8'h40,           32'h0, 4'hF, 32'h00000000);

        // Pure release: no new drivers, WAIT skipped, busy for two cycles.
        wb(1'b1, OFS_SHD_OEN_LO, 32'hFFFFFFFF, 4'hF, 32'h0);
        wb(1'b1, OFS_SHD_OEN_HI, 32'hFFFFFFFF, 4'hF, 32'h0);
        wb(1'b1, OFS_CTRL,       32'h1,        4'hF, 32'h0);
        chk("pr_busy_e0", 64'(busy), 64'd1);
        cyc_n(1);
        chk("pr_busy_e1", 64'(busy), 64'd1);
        cyc_n(1);
        chk("pr_busy_e2", 64'(busy), 64'd0);
        chk("pr_oe_n", 64'(oe_n), 64'(ALL1));
        chk("pr_re_n", 64'(re_n), 64'(ALL1));
        wb(1'b0, OFS_SHD_OEN_HI, 32'h0, 4'hF, 32'h00000FFF);
        wb(1'b0, OFS_LIVE_OEN_HI, 32'h0, 4'hF, 32'h00000FFF);

        // Turnaround: pad 1 released at E0+1, pad 8 driven at E0+6.
        pulse_reset();
        wb(1'b1, OFS_SHD_OEN_LO, 32'h003FFEBF, 4'hF, 32'h0);
        wb(1'b1, OFS_CTRL,       32'h1,        4'hF, 32'h0);
        chk("ta_oe_e0", 64'(oe_n), 64'(RSTV));
        for (int k = 1; k <= 5; k++) begin
            cyc_n(1);
            chk("ta_oe_mid", 64'(oe_n), 64'(mid_oe));
            chk("ta_busy_mid", 64'(busy), 64'd1);
        end
        cyc_n(1);
        chk("ta_oe_final", 64'(oe_n), 64'(fin_oe));
        chk("ta_busy_done", 64'(busy), 64'd0);

        // Commit while busy, byte-select shadow write mid-sequence.
        pulse_reset();
        wb(1'b1, OFS_SHD_OEN_LO, 32'h003FFEBF, 4'hF, 32'h0);
        wb(1'b1, OFS_SHD_REN_LO, 32'h12345678, 4'hF, 32'h0);
        wb(1'b1, OFS_CTRL,       32'h1,        4'hF, 32'h0);
        wb(1'b1, OFS_CTRL,       32'h1,        4'hF, 32'h0);
        wb(1'b1, OFS_SHD_REN_LO, 32'hAAAAAAAA, 4'h1, 32'h0);
        chk("cb_busy_mid", 64'(busy), 64'd1);
        cyc_n(3);
        chk("cb_busy_done", 64'(busy), 64'd0);
        chk("cb_oe_n", 64'(oe_n), 64'(fin_oe));
        chk("cb_re_n", 64'(re_n), 64'({12'hFFF, 32'h12345678}));
        wb(1'b0, OFS_STATUS,     32'h0, 4'hF, 32'h00000402);
        wb(1'b0, OFS_SHD_REN_LO, 32'h0, 4'hF, 32'h123456AA);
        // Clear plus commit in one write: ovr cleared, commit proceeds.
        wb(1'b1, OFS_CTRL, 32'h3, 4'hF, 32'h0);
        chk("cc_busy", 64'(busy), 64'd1);
        cyc_n(3);
        chk("cc_re_n", 64'(re_n), 64'({12'hFFF, 32'h123456AA}));
        wb(1'b0, OFS_STATUS, 32'h0, 4'hF, 32'h00000400);
        // Plain ovr clear.
        wb(1'b1, OFS_CTRL, 32'h1, 4'hF, 32'h0);
        wb(1'b1, OFS_CTRL, 32'h1, 4'hF, 32'h0);
        cyc_n(3);
        wb(1'b0, OFS_STATUS, 32'h0, 4'hF, 32'h00000402);
        wb(1'b1, OFS_CTRL,   32'h2, 4'hF, 32'h0);
        wb(1'b0, OFS_STATUS, 32'h0, 4'hF, 32'h00000400);

        // Abort: reset during WAIT forces outputs and drops all targets.
        pulse_reset();
        wb(1'b1, OFS_SHD_OEN_LO, 32'h003FFEBF, 4'hF, 32'h0);
        wb(1'b1, OFS_SHD_REN_LO, 32'h00000000, 4'hF, 32'h0);
        wb(1'b1, OFS_CTRL,       32'h1,        4'hF, 32'h0);
        cyc_n(2);
        chk("ab_busy_wait", 64'(busy), 64'd1);
        #2 resetb = 1'b0;
        #1;
        chk("ab_oe_n", 64'(oe_n), 64'(ALL1));
        chk("ab_re_n", 64'(re_n), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("ab_post_oe_n", 64'(oe_n), 64'(RSTV));
        chk("ab_post_re_n", 64'(re_n), 64'(ALL1));
        cyc_n(8);
        chk("ab_idle_oe_n", 64'(oe_n), 64'(RSTV));
        chk("ab_idle_busy", 64'(busy), 64'd0);
        wb(1'b0, OFS_STATUS,     32'h0, 4'hF, 32'h00000400);
        wb(1'b0, OFS_SHD_OEN_LO, 32'h0, 4'hF, 32'h003FFFBD);
        wb(1'b0, OFS_SHD_REN_LO, 32'h0, 4'hF, 32'hFFFFFFFF);

        cyc_n(2);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
